// File: rtl/eip_pkg.sv
// Shared definitions for the EIP redirect controller.
//   eip_state_e  : redirect FSM states (idle / redirect pending at fetch)
//   DefAddrW     : default EIP width
//   DefResetEip  : default EIP value after reset
//   trunc16()    : zero all bits above bit 15 (16-bit operand-size override)
package eip_pkg;

   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StPend = 1'b1
   } eip_state_e;

   localparam int unsigned DefAddrW    = 32;
   localparam logic [63:0] DefResetEip = 64'h0;
   localparam logic [63:0] Low16Mask   = 64'h0000_0000_0000_ffff;

   // Callers widen to 64 bits and cast the result back to their own width.
   function automatic logic [63:0] trunc16(input logic [63:0] v);
      return v & Low16Mask;
   endfunction

endpackage

// File: rtl/eip_target_sel.sv
// Writeback branch resolution: evaluates the CF/ZF conditions, picks the
// redirect target from the ALU result candidates (or the fall-through EIP
// when not taken) and applies 16-bit truncation on operand-size override.
// Ports:
//   wb_res_i        flattened candidates, candidate i at [i*ADDR_W +: ADDR_W]
//   wb_res_sel_i    candidate index; out-of-range selects candidate 0
//   wb_eip_next_i   fall-through EIP
//   wb_cond_*_i     condition enables, wb_flag_*_i resolved flags,
//   wb_*_exp_i      flag values required for taken
//   wb_size_over_i  truncate target to 16 bits
//   target_o        resolved redirect target
//   taken_o         branch conditions met
module eip_target_sel
   import eip_pkg::*;
#(
   parameter int unsigned ADDR_W  = DefAddrW,
   parameter int unsigned NUM_RES = 2,
   parameter int unsigned SEL_W   = (NUM_RES > 1) ? $clog2(NUM_RES) : 1
) (
   input  logic [NUM_RES*ADDR_W-1:0] wb_res_i,
   input  logic [SEL_W-1:0]          wb_res_sel_i,
   input  logic [ADDR_W-1:0]         wb_eip_next_i,
   input  logic                      wb_cond_wr_cf_i,
   input  logic                      wb_cond_wr_zf_i,
   input  logic                      wb_flag_cf_i,
   input  logic                      wb_flag_zf_i,
   input  logic                      wb_cf_exp_i,
   input  logic                      wb_zf_exp_i,
   input  logic                      wb_size_over_i,
   output logic [ADDR_W-1:0]         target_o,
   output logic                      taken_o
);

   logic              cf_met;
   logic              zf_met;
   logic [ADDR_W-1:0] cand;
   logic [ADDR_W-1:0] raw;

   assign cf_met  = ~wb_cond_wr_cf_i | (wb_flag_cf_i ~^ wb_cf_exp_i);
   assign zf_met  = ~wb_cond_wr_zf_i | (wb_flag_zf_i ~^ wb_zf_exp_i);
   assign taken_o = cf_met & zf_met;

   // Default to candidate 0 so an out-of-range select never yields X.
   always_comb begin
      cand = wb_res_i[0 +: ADDR_W];
      for (int i = 1; i < int'(NUM_RES); i++) begin
         if (int'(wb_res_sel_i) == i) begin
            cand = wb_res_i[i*ADDR_W +: ADDR_W];
         end
      end
   end

   assign raw = taken_o ? cand : wb_eip_next_i;

   always_comb begin
      target_o = raw;
      if (wb_size_over_i) begin
         target_o = ADDR_W'(trunc16(64'(raw)));
      end
   end

endmodule

// File: rtl/eip_redirect_ctrl.sv
// Architectural EIP owner for the writeback stage. Advances EIP from decode,
// resolves writeback control transfers into a redirect target, presents the
// redirect to fetch with a valid/ready handshake and emits a one-cycle flush.
// Optional build macro EIP_REDIR_STATS_EN adds saturating taken/redirect
// counters (taken_cnt, redir_cnt, STAT_W bits each).
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   de_v, de_eip_next          decode valid and sequential next EIP
//   fe_not_stall, de_br_stall  decode advance qualifiers
//   wb_v, wb_eip_change        writeback instruction redirects EIP
//   wb_res, wb_res_sel, wb_eip_next, wb_cond_*, wb_flag_*, wb_*_exp,
//   wb_size_over               target resolution inputs
//   fe_redir_ready             fetch accepts the redirect
//   eip                        architectural EIP
//   redir_valid, redir_target  redirect to fetch
//   flush                      one-cycle pipeline flush per redirect
//   wb_taken                   combinational: redirect is a taken transfer
module eip_redirect_ctrl
   import eip_pkg::*;
#(
   parameter int unsigned       ADDR_W    = DefAddrW,
   parameter int unsigned       NUM_RES   = 2,
   parameter int unsigned       SEL_W     = (NUM_RES > 1) ? $clog2(NUM_RES) : 1,
   parameter logic [ADDR_W-1:0] RESET_EIP = ADDR_W'(DefResetEip)
`ifdef EIP_REDIR_STATS_EN
   ,
   parameter int unsigned       STAT_W    = 16
`endif
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      de_v,
   input  logic [ADDR_W-1:0]         de_eip_next,
   input  logic                      fe_not_stall,
   input  logic                      de_br_stall,
   input  logic                      wb_v,
   input  logic                      wb_eip_change,
   input  logic [NUM_RES*ADDR_W-1:0] wb_res,
   input  logic [SEL_W-1:0]          wb_res_sel,
   input  logic [ADDR_W-1:0]         wb_eip_next,
   input  logic                      wb_cond_wr_cf,
   input  logic                      wb_cond_wr_zf,
   input  logic                      wb_flag_cf,
   input  logic                      wb_flag_zf,
   input  logic                      wb_cf_exp,
   input  logic                      wb_zf_exp,
   input  logic                      wb_size_over,
   input  logic                      fe_redir_ready,
   output logic [ADDR_W-1:0]         eip,
   output logic                      redir_valid,
   output logic [ADDR_W-1:0]         redir_target,
   output logic                      flush,
   output logic                      wb_taken
`ifdef EIP_REDIR_STATS_EN
   ,
   output logic [STAT_W-1:0]         taken_cnt,
   output logic [STAT_W-1:0]         redir_cnt
`endif
);

   eip_state_e        state_q, state_d;
   logic [ADDR_W-1:0] eip_q, eip_d;
   logic [ADDR_W-1:0] redir_target_q, redir_target_d;
   logic              redir_valid_q, redir_valid_d;
   logic              flush_q, flush_d;

   logic [ADDR_W-1:0] target;
   logic              taken;
   logic              wb_redir;
   logic              de_adv;

   eip_target_sel #(
      .ADDR_W  (ADDR_W),
      .NUM_RES (NUM_RES),
      .SEL_W   (SEL_W)
   ) u_target_sel (
      .wb_res_i        (wb_res),
      .wb_res_sel_i    (wb_res_sel),
      .wb_eip_next_i   (wb_eip_next),
      .wb_cond_wr_cf_i (wb_cond_wr_cf),
      .wb_cond_wr_zf_i (wb_cond_wr_zf),
      .wb_flag_cf_i    (wb_flag_cf),
      .wb_flag_zf_i    (wb_flag_zf),
      .wb_cf_exp_i     (wb_cf_exp),
      .wb_zf_exp_i     (wb_zf_exp),
      .wb_size_over_i  (wb_size_over),
      .target_o        (target),
      .taken_o         (taken)
   );

   assign wb_redir = wb_v & wb_eip_change;
   assign de_adv   = de_v & fe_not_stall & ~de_br_stall;
   assign wb_taken = wb_redir & taken;

   always_comb begin
      state_d        = state_q;
      eip_d          = eip_q;
      redir_target_d = redir_target_q;
      redir_valid_d  = redir_valid_q;
      flush_d        = 1'b0;

      unique case (state_q)
         StIdle: begin
            // Writeback redirect outranks a concurrent decode advance.
            if (wb_redir) begin
               eip_d          = target;
               redir_target_d = target;
               redir_valid_d  = 1'b1;
               flush_d        = 1'b1;
               state_d        = StPend;
            end else if (de_adv) begin
               eip_d = de_eip_next;
            end
         end
         StPend: begin
            // Decode is being flushed, so de_adv is ignored here. A new
            // redirect replaces the old one even if fetch is ready this
            // cycle, since fetch would be accepting the stale target.
            if (wb_redir) begin
               eip_d          = target;
               redir_target_d = target;
               flush_d        = 1'b1;
            end else if (fe_redir_ready) begin
               redir_valid_d = 1'b0;
               state_d       = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= StIdle;
         eip_q          <= RESET_EIP;
         redir_target_q <= '0;
         redir_valid_q  <= 1'b0;
         flush_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         eip_q          <= eip_d;
         redir_target_q <= redir_target_d;
         redir_valid_q  <= redir_valid_d;
         flush_q        <= flush_d;
      end
   end

   assign eip          = eip_q;
   assign redir_target = redir_target_q;
   assign redir_valid  = redir_valid_q;
   assign flush        = flush_q;

`ifdef EIP_REDIR_STATS_EN
   logic [STAT_W-1:0] taken_cnt_q;
   logic [STAT_W-1:0] redir_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         taken_cnt_q <= '0;
         redir_cnt_q <= '0;
      end else begin
         if (wb_taken && (taken_cnt_q != '1)) begin
            taken_cnt_q <= taken_cnt_q + STAT_W'(1);
         end
         if (wb_redir && (redir_cnt_q != '1)) begin
            redir_cnt_q <= redir_cnt_q + STAT_W'(1);
         end
      end
   end

   assign taken_cnt = taken_cnt_q;
   assign redir_cnt = redir_cnt_q;
`endif

endmodule

// File: tb/tb_eip_redirect_ctrl.sv
// Self-checking bench for eip_redirect_ctrl: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the
// redirect protocol. Counter checks are active when EIP_REDIR_STATS_EN is set.
module tb_eip_redirect_ctrl;

   localparam int unsigned AW   = 32;
   localparam int unsigned NRES = 3;
   localparam int unsigned SW   = 2;
   localparam int unsigned STW  = 2;

   logic              clk;
   logic              rst_n;
   logic              de_v;
   logic [AW-1:0]     de_eip_next;
   logic              fe_not_stall;
   logic              de_br_stall;
   logic              wb_v;
   logic              wb_eip_change;
   logic [NRES*AW-1:0] wb_res;
   logic [SW-1:0]     wb_res_sel;
   logic [AW-1:0]     wb_eip_next;
   logic              wb_cond_wr_cf;
   logic              wb_cond_wr_zf;
   logic              wb_flag_cf;
   logic              wb_flag_zf;
   logic              wb_cf_exp;
   logic              wb_zf_exp;
   logic              wb_size_over;
   logic              fe_redir_ready;
   logic [AW-1:0]     eip;
   logic              redir_valid;
   logic [AW-1:0]     redir_target;
   logic              flush;
   logic              wb_taken;
`ifdef EIP_REDIR_STATS_EN
   logic [STW-1:0]    taken_cnt;
   logic [STW-1:0]    redir_cnt;
`endif

   int checks = 0;
   int errors = 0;

   // Behavioural model of the architectural view.
   logic [AW-1:0] m_eip;
   logic [AW-1:0] m_target;
   logic          m_pending;
   logic          m_flush;
   int            m_taken_cnt;
   int            m_redir_cnt;

   eip_redirect_ctrl #(
      .ADDR_W    (AW),
      .NUM_RES   (NRES),
      .SEL_W     (SW),
      .RESET_EIP ('0)
`ifdef EIP_REDIR_STATS_EN
      ,
      .STAT_W    (STW)
`endif
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .de_v           (de_v),
      .de_eip_next    (de_eip_next),
      .fe_not_stall   (fe_not_stall),
      .de_br_stall    (de_br_stall),
      .wb_v           (wb_v),
      .wb_eip_change  (wb_eip_change),
      .wb_res         (wb_res),
      .wb_res_sel     (wb_res_sel),
      .wb_eip_next    (wb_eip_next),
      .wb_cond_wr_cf  (wb_cond_wr_cf),
      .wb_cond_wr_zf  (wb_cond_wr_zf),
      .wb_flag_cf     (wb_flag_cf),
      .wb_flag_zf     (wb_flag_zf),
      .wb_cf_exp      (wb_cf_exp),
      .wb_zf_exp      (wb_zf_exp),
      .wb_size_over   (wb_size_over),
      .fe_redir_ready (fe_redir_ready),
      .eip            (eip),
      .redir_valid    (redir_valid),
      .redir_target   (redir_target),
      .flush          (flush),
      .wb_taken       (wb_taken)
`ifdef EIP_REDIR_STATS_EN
      ,
      .taken_cnt      (taken_cnt),
      .redir_cnt      (redir_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic model_taken();
      logic cf_ok;
      logic zf_ok;
      cf_ok = !wb_cond_wr_cf || (wb_flag_cf == wb_cf_exp);
      zf_ok = !wb_cond_wr_zf || (wb_flag_zf == wb_zf_exp);
      return cf_ok && zf_ok;
   endfunction

   function automatic logic [AW-1:0] model_target();
      logic [NRES*AW-1:0] res;
      int                 idx;
      logic [AW-1:0]      t;
      res = wb_res;
      idx = (int'(wb_res_sel) < int'(NRES)) ? int'(wb_res_sel) : 0;
      t   = model_taken() ? res[idx*AW +: AW] : wb_eip_next;
      if (wb_size_over) t = t % 32'h0001_0000;
      return t;
   endfunction

   task automatic model_reset();
      m_eip       = '0;
      m_target    = '0;
      m_pending   = 1'b0;
      m_flush     = 1'b0;
      m_taken_cnt = 0;
      m_redir_cnt = 0;
   endtask

   task automatic clear_inputs();
      de_v           = 1'b0;
      de_eip_next    = '0;
      fe_not_stall   = 1'b1;
      de_br_stall    = 1'b0;
      wb_v           = 1'b0;
      wb_eip_change  = 1'b0;
      wb_res         = '0;
      wb_res_sel     = '0;
      wb_eip_next    = '0;
      wb_cond_wr_cf  = 1'b0;
      wb_cond_wr_zf  = 1'b0;
      wb_flag_cf     = 1'b0;
      wb_flag_zf     = 1'b0;
      wb_cf_exp      = 1'b0;
      wb_zf_exp      = 1'b0;
      wb_size_over   = 1'b0;
      fe_redir_ready = 1'b0;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".eip"}, 64'(eip), 64'(m_eip));
      chk({tag, ".valid"}, 64'(redir_valid), 64'(m_pending));
      chk({tag, ".target"}, 64'(redir_target), 64'(m_target));
      chk({tag, ".flush"}, 64'(flush), 64'(m_flush));
`ifdef EIP_REDIR_STATS_EN
      chk({tag, ".taken_cnt"}, 64'(taken_cnt), 64'(m_taken_cnt));
      chk({tag, ".redir_cnt"}, 64'(redir_cnt), 64'(m_redir_cnt));
`endif
   endtask

   // One clock: check the combinational output, apply the edge to the model,
   // then check registered outputs just after the edge.
   task automatic cycle(input string tag);
      logic          redir;
      logic          adv;
      logic          tk;
      logic [AW-1:0] t;
      int            cmax;
      #2;
      redir = wb_v && wb_eip_change;
      adv   = de_v && fe_not_stall && !de_br_stall;
      tk    = model_taken();
      t     = model_target();
      chk({tag, ".wb_taken"}, 64'(wb_taken), 64'(redir && tk));
      @(posedge clk);
      cmax    = (1 << STW) - 1;
      m_flush = 1'b0;
      if (redir) begin
         m_eip     = t;
         m_target  = t;
         m_pending = 1'b1;
         m_flush   = 1'b1;
         if (m_redir_cnt < cmax) m_redir_cnt++;
         if (tk && m_taken_cnt < cmax) m_taken_cnt++;
      end else if (m_pending) begin
         if (fe_redir_ready) m_pending = 1'b0;
      end else if (adv) begin
         m_eip = de_eip_next;
      end
      #1;
      check_outputs(tag);
   endtask

   task automatic set_redirect(input logic [AW-1:0] tgt);
      wb_v          = 1'b1;
      wb_eip_change = 1'b1;
      wb_cond_wr_cf = 1'b0;
      wb_cond_wr_zf = 1'b0;
      wb_size_over  = 1'b0;
      wb_res_sel    = 2'd1;
      wb_res[AW +: AW] = tgt;
   endtask

   initial begin
      clear_inputs();
      model_reset();
      rst_n = 1'b0;

      // Reset state
      #3;
      chk("reset.eip", 64'(eip), 64'h0);
      chk("reset.valid", 64'(redir_valid), 64'h0);
      chk("reset.flush", 64'(flush), 64'h0);
      chk("reset.target", 64'(redir_target), 64'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Decode advance
      de_v        = 1'b1;
      de_eip_next = 32'h1004;
      cycle("de_adv");
      chk("de_adv.eip_const", 64'(eip), 64'h1004);

      // Taken conditional on ZF
      clear_inputs();
      wb_v          = 1'b1;
      wb_eip_change = 1'b1;
      wb_cond_wr_zf = 1'b1;
      wb_zf_exp     = 1'b1;
      wb_flag_zf    = 1'b1;
      wb_res_sel    = 2'd1;
      wb_res[AW +: AW] = 32'h2000;
      wb_eip_next   = 32'h1010;
      #2;
      chk("taken.wb_taken_const", 64'(wb_taken), 64'h1);
      cycle("taken");
      chk("taken.eip_const", 64'(eip), 64'h2000);
      chk("taken.flush_const", 64'(flush), 64'h1);
      clear_inputs();
      fe_redir_ready = 1'b1;
      cycle("taken_accept");
      chk("taken.flush_one_cycle", 64'(flush), 64'h0);
      chk("taken.valid_dropped", 64'(redir_valid), 64'h0);

      // Not taken: fall-through target
      clear_inputs();
      wb_v          = 1'b1;
      wb_eip_change = 1'b1;
      wb_cond_wr_zf = 1'b1;
      wb_zf_exp     = 1'b1;
      wb_flag_zf    = 1'b0;
      wb_res_sel    = 2'd1;
      wb_res[AW +: AW] = 32'h2000;
      wb_eip_next   = 32'h1010;
      cycle("not_taken");
      chk("not_taken.target_const", 64'(redir_target), 64'h1010);
      clear_inputs();
      fe_redir_ready = 1'b1;
      cycle("not_taken_accept");

      // Operand-size override truncation
      set_redirect(32'h0001_2345);
      wb_size_over = 1'b1;
      cycle("size_over");
      chk("size_over.target_const", 64'(redir_target), 64'h2345);
      clear_inputs();
      fe_redir_ready = 1'b1;
      cycle("size_over_accept");

      // Out-of-range select falls back to candidate 0
      set_redirect(32'h0bad_0000);
      wb_res[0 +: AW] = 32'h0000_7700;
      wb_res_sel      = 2'd3;
      cycle("sel_oob");
      chk("sel_oob.target_const", 64'(redir_target), 64'h7700);
      clear_inputs();
      fe_redir_ready = 1'b1;
      cycle("sel_oob_accept");

      // Held redirect with decode activity ignored
      set_redirect(32'h4000);
      cycle("hold_start");
      clear_inputs();
      de_v        = 1'b1;
      de_eip_next = 32'h9999;
      for (int i = 0; i < 3; i++) begin
         cycle("hold");
         chk("hold.target_const", 64'(redir_target), 64'h4000);
         chk("hold.eip_const", 64'(eip), 64'h4000);
      end
      fe_redir_ready = 1'b1;
      de_v           = 1'b0;
      cycle("hold_accept");
      chk("hold_accept.valid_const", 64'(redir_valid), 64'h0);

      // Collision: new redirect in PEND while fetch is ready
      set_redirect(32'h5000);
      cycle("coll_first");
      set_redirect(32'h3000);
      fe_redir_ready = 1'b1;
      cycle("coll_second");
      chk("coll.target_const", 64'(redir_target), 64'h3000);
      chk("coll.valid_const", 64'(redir_valid), 64'h1);
      chk("coll.flush_const", 64'(flush), 64'h1);
      clear_inputs();
      fe_redir_ready = 1'b1;
      cycle("coll_accept");

      // Simultaneous wb_redir and de_adv in IDLE
      set_redirect(32'h6000);
      de_v        = 1'b1;
      de_eip_next = 32'h7777;
      cycle("simul");
      chk("simul.eip_const", 64'(eip), 64'h6000);

      // Reset while a redirect is pending
      clear_inputs();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("rst_pend.valid", 64'(redir_valid), 64'h0);
      chk("rst_pend.eip", 64'(eip), 64'h0);
      set_redirect(32'h8000);
      @(posedge clk);
      #1;
      check_outputs("rst_held");
      clear_inputs();
      rst_n = 1'b1;

      // Five back-to-back taken redirects (saturates 2-bit counters)
      for (int i = 0; i < 5; i++) begin
         set_redirect(32'h100 * (i + 1));
         cycle("sat");
      end
`ifdef EIP_REDIR_STATS_EN
      chk("sat.taken_cnt_const", 64'(taken_cnt), 64'h3);
      chk("sat.redir_cnt_const", 64'(redir_cnt), 64'h3);
`endif
      clear_inputs();
      fe_redir_ready = 1'b1;
      cycle("sat_accept");

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         de_v           = 1'($urandom_range(0, 1));
         de_eip_next    = $urandom;
         fe_not_stall   = ($urandom_range(0, 3) != 0);
         de_br_stall    = ($urandom_range(0, 3) == 0);
         wb_v           = ($urandom_range(0, 2) == 0);
         wb_eip_change  = ($urandom_range(0, 1) == 0);
         wb_res         = {$urandom, $urandom, $urandom};
         wb_res_sel     = 2'($urandom_range(0, 3));
         wb_eip_next    = $urandom;
         wb_cond_wr_cf  = 1'($urandom_range(0, 1));
         wb_cond_wr_zf  = 1'($urandom_range(0, 1));
         wb_flag_cf     = 1'($urandom_range(0, 1));
         wb_flag_zf     = 1'($urandom_range(0, 1));
         wb_cf_exp      = 1'($urandom_range(0, 1));
         wb_zf_exp      = 1'($urandom_range(0, 1));
         wb_size_over   = ($urandom_range(0, 3) == 0);
         fe_redir_ready = 1'($urandom_range(0, 1));
         cycle("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/eip_redirect_ctrl.md
Name: eip_redirect_ctrl

Overview:
- Parametrised EIP owner for the writeback stage. Holds the architectural EIP, advances it from decode, and resolves writeback control transfers (conditional/unconditional) into a redirect target.
- Adds a registered redirect handshake to fetch and a one-cycle pipeline flush pulse. The redirect is held until fetch accepts it.
- Generalised in address width and in the number of ALU result candidates for the target.

Parameters:
- ADDR_W, 32, EIP/target width.
- NUM_RES, 2, number of writeback ALU result candidates for the branch target (≥1).
- SEL_W, $clog2(NUM_RES) (min 1), width of the result select.
- RESET_EIP, 0, EIP value after reset.
- STAT_W, 16, counter width (optional feature only).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- de_v  in  1  decode stage valid
- de_eip_next  in  ADDR_W  sequential next EIP from decode
- fe_not_stall  in  1  fetch not stalled
- de_br_stall  in  1  decode holding for an unresolved branch
- wb_v  in  1  writeback valid
- wb_eip_change  in  1  writeback instruction alters EIP
- wb_res  in  NUM_RES*ADDR_W  flattened ALU results; candidate i = wb_res[i*ADDR_W +: ADDR_W]
- wb_res_sel  in  SEL_W  target candidate index
- wb_eip_next  in  ADDR_W  fall-through EIP of the writeback instruction
- wb_cond_wr_cf, wb_cond_wr_zf  in  1 each  branch conditioned on CF / ZF
- wb_flag_cf, wb_flag_zf  in  1 each  resolved flags
- wb_cf_exp, wb_zf_exp  in  1 each  flag values required for taken
- wb_size_over  in  1  16-bit operand-size override; truncate target
- fe_redir_ready  in  1  fetch accepts the redirect
- eip  out  ADDR_W  architectural EIP
- redir_valid  out  1  redirect pending to fetch
- redir_target  out  ADDR_W  redirect address
- flush  out  1  one-cycle pipeline flush pulse
- wb_taken  out  1  combinational: writeback redirect is a taken transfer

Behaviour:
- Reset (async on rst_n low):
  - eip = RESET_EIP; redir_valid = 0; redir_target = 0; flush = 0; state = IDLE.
  - Reset asserted mid-PEND abandons the redirect.
- Condition resolution (combinational):
  - cf_met = ~wb_cond_wr_cf | (wb_flag_cf ~^ wb_cf_exp); zf_met likewise.
  - taken = cf_met & zf_met.
- Target:
  - raw = taken ? wb_res[sel] : wb_eip_next.
  - wb_res_sel ≥ NUM_RES selects candidate 0.
  - If wb_size_over, target = {zeros, raw[15:0]}; else target = raw.
- Events:
  - wb_redir = wb_v & wb_eip_change.
  - de_adv = de_v & fe_not_stall & ~de_br_stall.
  - wb_taken = wb_redir & taken.
- FSM IDLE:
  - wb_redir: eip <= target; redir_target <= target; redir_valid <= 1; flush <= 1 next cycle; go to PEND. wb_redir wins over a simultaneous de_adv.
  - Else de_adv: eip <= de_eip_next.
  - Else hold.
- FSM PEND:
  - de_adv is ignored (pipeline is flushing).
  - wb_redir: overwrite eip/redir_target with the new target, pulse flush again, stay in PEND. This applies even if fe_redir_ready is high in the same cycle; the new target takes precedence and is not yet accepted.
  - Else fe_redir_ready: redir_valid <= 0; go to IDLE.
  - Else hold; redir_target stays stable while redir_valid is high.
- Latency: one cycle from wb_redir to eip/redir_valid/flush. Fetch handshake completes on the cycle with redir_valid & fe_redir_ready.
- flush is high exactly one cycle per accepted wb_redir.

Optional Feature:
- Macro EIP_REDIR_STATS_EN.
- Defined: adds outputs taken_cnt and redir_cnt (STAT_W each, reset 0).
  - taken_cnt increments on wb_taken; redir_cnt increments on each wb_redir.
  - Both counters saturate at all-ones.
  - They ignore wb_redir while rst_n is low.
- Undefined: no counters and no extra ports; behaviour is otherwise identical.

Decomposition:
- Shared package eip_pkg:
  - state enum (IDLE, PEND);
  - default ADDR_W and RESET_EIP constants;
  - function for 16-bit truncation.
- One sub-module, eip_target_sel: combinational condition resolution plus candidate mux and truncation. Outputs target and taken.
- The FSM and registers stay in the top module.

Test Plan:
- Reset: rst_n low → eip=RESET_EIP (0), redir_valid=0, flush=0. Release, then de_adv with de_eip_next=0x1004 → eip=0x1004 next cycle.
- Taken conditional: wb_cond_wr_zf=1, wb_zf_exp=1, wb_flag_zf=1, wb_res_sel=1, candidate1=0x2000 → eip=0x2000, redir_valid=1, flush pulse of one cycle, wb_taken=1.
- Not taken: same as above but wb_flag_zf=0, wb_eip_next=0x1010 → target=0x1010, wb_taken=0. Add wb_size_over with candidate=0x0001_2345 taken → target=0x0000_2345.
- Held redirect: fe_redir_ready=0 for 3 cycles → redir_valid and redir_target stable and de_adv ignored. Ready=1 → IDLE next cycle.
- Collision: in PEND, new wb_redir to 0x3000 with fe_redir_ready=1 → target=0x3000, still PEND, second flush pulse. Simultaneous wb_redir and de_adv in IDLE → wb target wins.
- With EIP_REDIR_STATS_EN and STAT_W=2: 5 taken redirects → taken_cnt=3 (saturated), redir_cnt=3.
